// File: rtl/config_loader.sv
// Streams kernel configuration words from an OBI read port to the
// deserializer through a credit-limited response FIFO.
module config_loader #(
  parameter int FIFO_DEPTH       = 4,
  parameter int WORDS_PER_KERNEL = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] base_addr_i,
  input  logic [7:0]  num_kernels_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        ready_i,
  output logic [31:0] data_o,
  output logic        enable_o,
  output logic        word_last_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int KW = $clog2(WORDS_PER_KERNEL + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state_q;
  logic [31:0]   addr_q;
  logic [10:0]   total_q;
  logic [10:0]   issued_q;
  logic [10:0]   received_q;
  logic [10:0]   popped_q;
  logic [KW-1:0] kw_q;
  logic          zero_done_q;

  logic [31:0]   fifo_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [CW-1:0] count_q;

  logic [10:0] total_d;
  logic [10:0] used;
  logic        credit_ok;
  logic        grant;
  logic        push;
  logic        pop;
  logic        fifo_ne;

  assign total_d = 11'(num_kernels_i) * 11'(WORDS_PER_KERNEL);

  // Words granted but not yet popped: in flight plus buffered.
  assign used      = (issued_q - received_q) + 11'(count_q);
  assign credit_ok = used < 11'(FIFO_DEPTH);

  assign mem_req_o  = (state_q == S_FETCH)
                    && (issued_q < total_q)
                    && credit_ok;
  assign mem_addr_o = addr_q;
  assign mem_we_o   = 1'b0;
  assign mem_be_o   = 4'hF;
  assign grant      = mem_req_o & mem_gnt_i;

  assign fifo_ne = count_q != '0;
  assign push    = mem_rvalid_i
                 && (state_q != S_IDLE)
                 && (count_q != CW'(FIFO_DEPTH));
  assign enable_o = fifo_ne & ready_i;
  assign pop      = enable_o;
  assign data_o   = fifo_ne ? fifo_q[rptr_q] : '0;

  assign word_last_o = enable_o
                     && (kw_q == KW'(WORDS_PER_KERNEL - 1));

  assign busy_o = state_q != S_IDLE;
  assign done_o = (state_q == S_DONE) | zero_done_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      total_q     <= '0;
      issued_q    <= '0;
      received_q  <= '0;
      popped_q    <= '0;
      kw_q        <= '0;
      zero_done_q <= 1'b0;
    end else begin
      zero_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (num_kernels_i == 8'd0) begin
              zero_done_q <= 1'b1;
            end else begin
              addr_q     <= base_addr_i;
              total_q    <= total_d;
              issued_q   <= '0;
              received_q <= '0;
              popped_q   <= '0;
              kw_q       <= '0;
              state_q    <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (grant && (issued_q + 11'd1 == total_q))
            state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (popped_q == total_q)
            state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
      if (grant) begin
        issued_q <= issued_q + 11'd1;
        addr_q   <= addr_q + 32'd4;
      end
      if (push)
        received_q <= received_q + 11'd1;
      if (pop) begin
        popped_q <= popped_q + 11'd1;
        if (kw_q == KW'(WORDS_PER_KERNEL - 1))
          kw_q <= '0;
        else
          kw_q <= kw_q + KW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push)
        wptr_q <= wptr_q + AW'(1);
      if (pop)
        rptr_q <= rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: data_o is gated by the occupancy count.
  always_ff @(posedge clk_i) begin
    if (push)
      fifo_q[wptr_q] <= mem_rdata_i;
  end

endmodule

// File: tb/tb_config_loader.sv
// Self-checking bench for config_loader against a word-stream
// reference model with randomized memory and downstream timing.
module tb_config_loader;

  localparam int DEPTH = 4;
  localparam int WPK   = 5;
  localparam int BUDGET = 3000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] base_addr_i;
  logic [7:0]  num_kernels_i;
  logic        busy_o;
  logic        done_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        ready_i;
  logic [31:0] data_o;
  logic        enable_o;
  logic        word_last_o;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] salt;
  logic [31:0] rsp_q [$];
  int          g_stall_grants;
  logic        g_stall_req;

  config_loader #(
    .FIFO_DEPTH(DEPTH),
    .WORDS_PER_KERNEL(WPK)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .start_i(start_i),
    .base_addr_i(base_addr_i),
    .num_kernels_i(num_kernels_i),
    .busy_o(busy_o),
    .done_o(done_o),
    .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o),
    .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i),
    .ready_i(ready_i),
    .data_o(data_o),
    .enable_o(enable_o),
    .word_last_o(word_last_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ salt;
  endfunction

  task automatic run_load(
    input logic [31:0] base,
    input int          nk,
    input int          stall_ready,
    input int          gnt_delay,
    input bit          rnd,
    input int          restart_cyc,
    input int          abort_cyc
  );
    int          total;
    int          grants;
    int          pops;
    int          recv;
    int          dones;
    int          cyc;
    int          reqseen;
    int          occ;
    logic        prev_pend;
    logic [31:0] prev_addr;
    logic [31:0] exp_a;
    total = nk * WPK;
    grants = 0; pops = 0; recv = 0; dones = 0;
    cyc = 0; reqseen = 0; prev_pend = 1'b0;
    prev_addr = '0;
    rsp_q.delete();
    salt = $urandom;
    @(negedge clk_i);
    start_i = 1'b1;
    base_addr_i = base;
    num_kernels_i = 8'(nk);
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0;
    while (dones == 0 && cyc < BUDGET) begin
      if (cyc == abort_cyc) return;
      ready_i = (cyc < stall_ready) ? 1'b0
              : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      mem_gnt_i = (reqseen < gnt_delay) ? 1'b0
                : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      if (rsp_q.size() > 0 && (!rnd || $urandom_range(0, 2) != 0)) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i = mem_word(rsp_q.pop_front());
      end else begin
        mem_rvalid_i = 1'b0;
        mem_rdata_i = $urandom;
      end
      start_i = (cyc == restart_cyc);
      if (cyc == restart_cyc) begin
        base_addr_i = ~base;
        num_kernels_i = 8'(nk + 3);
      end
      #1;
      n_cmp++;
      if (busy_o !== 1'b1) begin
        n_err++;
        $display("FAIL busy cyc=%0d got=%b exp=1", cyc, busy_o);
      end
      if (prev_pend) begin
        n_cmp++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== prev_addr) begin
          n_err++;
          $display("FAIL obi_stable cyc=%0d got req=%b addr=%h exp req=1 addr=%h",
                   cyc, mem_req_o, mem_addr_o, prev_addr);
        end
      end
      if (grants - pops >= DEPTH) begin
        n_cmp++;
        if (mem_req_o !== 1'b0) begin
          n_err++;
          $display("FAIL credit cyc=%0d got req=%b exp=0 outstanding=%0d",
                   cyc, mem_req_o, grants - pops);
        end
      end
      if (grants >= total) begin
        n_cmp++;
        if (mem_req_o !== 1'b0) begin
          n_err++;
          $display("FAIL extra_req cyc=%0d got req=%b exp=0", cyc, mem_req_o);
        end
      end
      prev_pend = mem_req_o && !mem_gnt_i;
      prev_addr = mem_addr_o;
      if (mem_req_o) reqseen++;
      if (mem_req_o && mem_gnt_i) begin
        exp_a = base + 32'(4 * grants);
        n_cmp++;
        if (mem_addr_o !== exp_a) begin
          n_err++;
          $display("FAIL addr grant=%0d got=%h exp=%h", grants, mem_addr_o, exp_a);
        end
        rsp_q.push_back(mem_addr_o);
        grants++;
      end
      occ = recv - pops;
      n_cmp++;
      if (enable_o !== (ready_i && occ > 0)) begin
        n_err++;
        $display("FAIL enable cyc=%0d got=%b exp=%b", cyc, enable_o,
                 ready_i && occ > 0);
      end
      n_cmp++;
      if (word_last_o !== (enable_o && (pops % WPK == WPK - 1))) begin
        n_err++;
        $display("FAIL word_last cyc=%0d pop=%0d got=%b", cyc, pops, word_last_o);
      end
      if (occ == 0) begin
        n_cmp++;
        if (data_o !== 32'd0) begin
          n_err++;
          $display("FAIL data_empty cyc=%0d got=%h exp=0", cyc, data_o);
        end
      end
      if (enable_o) begin
        exp_a = base + 32'(4 * pops);
        n_cmp++;
        if (data_o !== mem_word(exp_a)) begin
          n_err++;
          $display("FAIL data word=%0d got=%h exp=%h", pops, data_o,
                   mem_word(exp_a));
        end
        pops++;
      end
      if (mem_rvalid_i) recv++;
      if (cyc == stall_ready - 1) begin
        g_stall_grants = grants;
        g_stall_req = mem_req_o;
      end
      if (done_o) begin
        dones++;
        n_cmp++;
        if (pops != total || grants != total) begin
          n_err++;
          $display("FAIL done_count got pops=%0d grants=%0d exp=%0d",
                   pops, grants, total);
        end
      end
      @(negedge clk_i);
      cyc++;
    end
    if (dones == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout got done=0 exp=1 after %0d cycles", cyc);
      return;
    end
    start_i = 1'b0;
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0;
    ready_i = 1'b1;
    #1;
    n_cmp++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || mem_req_o !== 1'b0) begin
      n_err++;
      $display("FAIL after_done got busy=%b done=%b req=%b exp 0/0/0",
               busy_o, done_o, mem_req_o);
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    start_i = 1'b0;
    base_addr_i = '0;
    num_kernels_i = '0;
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i = '0;
    ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    n_cmp++;
    if ({mem_req_o, busy_o, done_o, enable_o, word_last_o} !== 5'b0
        || mem_addr_o !== 32'd0 || data_o !== 32'd0) begin
      n_err++;
      $display("FAIL reset got req=%b addr=%h busy=%b done=%b en=%b data=%h",
               mem_req_o, mem_addr_o, busy_o, done_o, enable_o, data_o);
    end
    n_cmp++;
    if (mem_we_o !== 1'b0 || mem_be_o !== 4'hF) begin
      n_err++;
      $display("FAIL ties got we=%b be=%h exp 0/f", mem_we_o, mem_be_o);
    end
    rst_i = 1'b0;
  endtask

  task automatic test_single;
    run_load(32'h0000_1000, 1, 0, 0, 1'b0, -1, -1);
  endtask

  task automatic test_backpressure;
    run_load(32'h0000_2000, 2, 12, 0, 1'b0, -1, -1);
    n_cmp++;
    if (g_stall_grants > DEPTH) begin
      n_err++;
      $display("FAIL stall_grants got=%0d exp<=%0d", g_stall_grants, DEPTH);
    end
    n_cmp++;
    if (g_stall_req !== 1'b0) begin
      n_err++;
      $display("FAIL stall_req got=%b exp=0", g_stall_req);
    end
  endtask

  task automatic test_grant_delay;
    run_load(32'h0000_3000, 1, 0, 3, 1'b0, -1, -1);
  endtask

  task automatic test_zero_kernels;
    @(negedge clk_i);
    start_i = 1'b1;
    num_kernels_i = 8'd0;
    base_addr_i = 32'h0000_4000;
    #1;
    n_cmp++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL zero_pre got done=%b busy=%b exp 0/0", done_o, busy_o);
    end
    @(negedge clk_i);
    start_i = 1'b0;
    #1;
    n_cmp++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || mem_req_o !== 1'b0) begin
      n_err++;
      $display("FAIL zero_done got done=%b busy=%b req=%b exp 1/0/0",
               done_o, busy_o, mem_req_o);
    end
    @(negedge clk_i);
    #1;
    n_cmp++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || mem_req_o !== 1'b0) begin
      n_err++;
      $display("FAIL zero_after got done=%b busy=%b req=%b exp 0/0/0",
               done_o, busy_o, mem_req_o);
    end
  endtask

  task automatic test_start_busy;
    run_load(32'h0000_5000, 2, 0, 0, 1'b0, 2, -1);
  endtask

  task automatic test_reset_mid;
    run_load(32'h0000_6000, 3, 0, 0, 1'b0, -1, 6);
    rst_i = 1'b1;
    start_i = 1'b0;
    mem_gnt_i = 1'b1;
    mem_rvalid_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk_i);
    #1;
    n_cmp++;
    if ({mem_req_o, busy_o, done_o, enable_o, word_last_o} !== 5'b0
        || mem_addr_o !== 32'd0 || data_o !== 32'd0) begin
      n_err++;
      $display("FAIL mid_reset got req=%b addr=%h busy=%b done=%b en=%b data=%h",
               mem_req_o, mem_addr_o, busy_o, done_o, enable_o, data_o);
    end
    rst_i = 1'b0;
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk_i);
    mem_rvalid_i = 1'b0;
    rsp_q.delete();
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (enable_o !== 1'b0 || data_o !== 32'd0 || busy_o !== 1'b0) begin
        n_err++;
        $display("FAIL stale_rvalid i=%0d got en=%b data=%h busy=%b",
                 i, enable_o, data_o, busy_o);
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_wrap;
    run_load(32'hFFFF_FFF8, 1, 0, 0, 1'b0, -1, -1);
  endtask

  task automatic test_back_to_back;
    logic [31:0] b;
    int          nk;
    for (int i = 0; i < 6; i++) begin
      b = $urandom & 32'hFFFF_FFFC;
      nk = $urandom_range(1, 4);
      run_load(b, nk, int'($urandom_range(0, 8)), 0, 1'b1, -1, -1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_grant_delay();
    test_zero_kernels();
    test_start_busy();
    test_reset_mid();
    test_wrap();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/config_loader.md
Name: config_loader

Overview:
- Fetches kernel configuration words from memory over an OBI-style read port and streams them, one 32-bit word per cycle, to the configuration deserializer.
- The deserializer packs each group of WORDS_PER_KERNEL consecutive words into one kernel configuration.
- A credit-limited FIFO decouples memory latency from downstream backpressure.
- The block is started by the CGRA control registers and reports busy/done.

Parameters:
- FIFO_DEPTH, 4, response buffer entries (power of two, ≥2); also the maximum number of words in flight.
- WORDS_PER_KERNEL, 5, 32-bit words per kernel configuration.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  start pulse; sampled only in IDLE.
- base_addr_i  in  32  byte address of the first word; latched on start.
- num_kernels_i  in  8  number of kernels to load; latched on start.
- busy_o  out  1  high from the cycle after start until done_o.
- done_o  out  1  one-cycle pulse when all words have been delivered.
- mem_req_o  out  1  read request.
- mem_addr_o  out  32  word-aligned request address.
- mem_we_o  out  1  tied 0.
- mem_be_o  out  4  tied 4'hF.
- mem_gnt_i  in  1  request accepted.
- mem_rvalid_i  in  1  response valid.
- mem_rdata_i  in  32  response data.
- ready_i  in  1  downstream can accept a word this cycle.
- data_o  out  32  FIFO head; 0 when the FIFO is empty.
- enable_o  out  1  word transfer this cycle; drives deserializer enable.
- word_last_o  out  1  high with enable_o on the last word of each kernel.

Behaviour:
- Reset (synchronous): FSM=IDLE, FIFO emptied, all counters 0. Output values after reset:
  - mem_req_o=0, mem_addr_o=0, busy_o=0, done_o=0.
  - enable_o=0, data_o=0, word_last_o=0.
- Internal counts are 11 bits: total = num_kernels_i*WORDS_PER_KERNEL (max 1275). Counters:
  - issued: granted requests.
  - received: accepted responses.
  - popped: words delivered downstream.
- FSM states:
  - IDLE: on start_i with num_kernels_i==0, pulse done_o next cycle and stay IDLE; no request is issued. On start_i with num_kernels_i>0, latch address and total, clear counters, go FETCH.
  - FETCH: request while issued<total. On mem_req_o&mem_gnt_i: issued++, address +=4. Move to DRAIN in the cycle issued reaches total.
  - DRAIN: no requests. When popped==total, go DONE.
  - DONE: done_o=1 for exactly one cycle, then IDLE.
- busy_o=1 in FETCH, DRAIN and DONE.
- Credit rule: a new request is raised only if (issued-received)+fifo_count < FIFO_DEPTH. The FIFO therefore never overflows, and rvalid never arrives when the FIFO is full.
- OBI stability: once mem_req_o is high, it and mem_addr_o stay constant until mem_gnt_i. A credit change never drops a pending request.
- Back-to-back issue: a new request may be raised in the cycle after a grant.
- Address arithmetic: modulo 2^32, so wrap-around is silent.
- Response path: mem_rvalid_i writes mem_rdata_i into the FIFO tail, with in-order responses. The earliest enable_o for that word is the next cycle; there is no bypass.
- Output:
  - enable_o = fifo_not_empty & ready_i.
  - Pop on enable_o.
  - word_last_o = enable_o & (popped mod WORDS_PER_KERNEL == WORDS_PER_KERNEL-1).
- Simultaneous push and pop in one cycle are both performed, with fifo_count unchanged.
- A pop and a grant in the same cycle both update their counters.
- start_i while busy_o=1 is ignored.
- mem_rvalid_i in IDLE is discarded. This covers stale responses after a reset mid-operation.
- Reset mid-operation: all state returns to reset values in the next cycle and buffered words are dropped. The downstream deserializer must be reset alongside this block.

Test Plan:
1. Single kernel: base 0x0000_1000, num_kernels=1, gnt always 1, rvalid one cycle after gnt, ready=1.
   - Addresses are 0x1000, 0x1004, 0x1008, 0x100C, 0x1010.
   - Five enable_o pulses carry the memory data in order; word_last_o is on the 5th.
   - done_o pulses once, then busy_o=0.
2. Backpressure: num_kernels=2, ready_i=0 for the first 12 cycles.
   - At most 4 grants occur before the stall; mem_req_o stays low while credits are exhausted.
   - After ready_i=1, 10 words arrive in order with no loss; word_last_o is on words 5 and 10.
3. Grant delay: mem_gnt_i held 0 for 3 cycles on the first request → mem_req_o=1 and mem_addr_o=base are stable over all 4 cycles.
4. Zero kernels: start_i with num_kernels=0 → done_o=1 one cycle later, busy_o never set, mem_req_o never set.
5. Start while busy, then reset:
   - A second start_i during FETCH does not change base or total.
   - rst_i asserted mid-FETCH gives all outputs 0 in the next cycle.
   - A subsequent late mem_rvalid_i produces no enable_o.
6. Address wrap: base 0xFFFF_FFF8, num_kernels=1 → addresses are 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004, 0x0000_0008.
